// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: drives instruction memory, registers
// the returned word and hands it to decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 15,
  parameter int PROG_LEN = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               restart,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted,
  output logic               fault
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, HALT, FLT
  } state_t;

  localparam logic [ADDR_W:0]   LEN  = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              load;
  logic              jump_ok;
  logic              jumping;

  assign imem_addr = pc;
  assign load      = !instr_valid || instr_ready;
  assign jump_ok   = {1'b0, jump_addr} < LEN;
  assign jumping   = jump_en && (state == FETCH || state == DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else if (restart) begin
      state       <= IDLE;
      pc          <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else if (jumping) begin
      // a redirect always drops the pending word
      instr_valid <= 1'b0;
      if (jump_ok) begin
        pc    <= jump_addr;
        state <= FETCH;
      end else begin
        state  <= FLT;
        halted <= 1'b1;
        fault  <= 1'b1;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (run) state <= FETCH;
        end
        FETCH: begin
          if (load) begin
            instr       <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            if (pc == LAST) state <= DRAIN;
            else            pc    <= pc + 1'b1;
          end
        end
        DRAIN: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            state       <= HALT;
            halted      <= 1'b1;
          end
        end
        HALT, FLT: begin
          instr_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table, directed corner sequences and
// randomized handshake/jump traffic against a transfer-level stream model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        restart = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic [7:0]  imem_addr;
  logic [14:0] imem_data;
  logic [14:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        halted;
  logic        fault;

  logic [14:0] mem [256];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .restart(restart),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted), .fault(fault)
  );

  typedef struct {
    logic       r, rs, je;
    logic [7:0] ja;
    logic       rdy;
    logic       v;
    logic [7:0] ipc;
    logic [7:0] addr;
    logic       h, f;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // apply inputs at a falling edge, return at the next falling edge
  task automatic cyc(input logic r, rs, je, input logic [7:0] ja,
                     input logic rd);
    run = r; restart = rs; jump_en = je;
    jump_addr = ja; instr_ready = rd;
    @(negedge clk);
  endtask

  task automatic chk_word(input string n, input logic [7:0] p);
    chk({n, "_valid"}, 32'(instr_valid), 1);
    chk({n, "_pc"}, 32'(instr_pc), 32'(p));
    chk({n, "_instr"}, 32'(instr), 32'(mem[p]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 0; restart = 0; jump_en = 0; instr_ready = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_pc;
    logic       exp_halt, seen, jumped, fin, rd, je;
    logic [7:0] ja;

    for (int i = 0; i < 256; i++) mem[i] = 15'($urandom);

    tbl[0]  = '{1,0,0,  0,1, 0, 0, 0,0,0};
    tbl[1]  = '{1,0,0,  0,1, 1, 0, 1,0,0};
    tbl[2]  = '{1,0,0,  0,1, 1, 1, 2,0,0};
    tbl[3]  = '{1,0,0,  0,1, 1, 2, 3,0,0};
    tbl[4]  = '{1,0,1, 10,1, 0, 0,10,0,0};
    tbl[5]  = '{1,0,0,  0,1, 1,10,11,0,0};
    tbl[6]  = '{1,0,0,  0,1, 1,11,12,0,0};
    tbl[7]  = '{1,0,0,  0,1, 1,12,13,0,0};
    tbl[8]  = '{1,0,0,  0,1, 1,13,14,0,0};
    tbl[9]  = '{1,0,0,  0,1, 1,14,14,0,0};
    tbl[10] = '{1,0,0,  0,1, 0, 0,14,1,0};
    tbl[11] = '{1,0,1,  3,1, 0, 0,14,1,0};
    tbl[12] = '{0,1,0,  0,1, 0, 0, 0,0,0};
    tbl[13] = '{1,0,0,  0,1, 0, 0, 0,0,0};
    tbl[14] = '{1,0,0,  0,1, 1, 0, 1,0,0};
    tbl[15] = '{1,0,1, 20,1, 0, 0, 1,1,1};
    tbl[16] = '{1,0,1,  2,1, 0, 0, 1,1,1};
    tbl[17] = '{0,1,0,  0,1, 0, 0, 0,0,0};
    tbl[18] = '{0,0,0,  0,1, 0, 0, 0,0,0};

    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_instr", 32'(instr), 0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].r, tbl[i].rs, tbl[i].je, tbl[i].ja, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].h));
      chk($sformatf("tbl%0d_fault", i), 32'(fault), 32'(tbl[i].f));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_pc", i), 32'(instr_pc), 32'(tbl[i].ipc));
        chk($sformatf("tbl%0d_instr", i), 32'(instr), 32'(mem[tbl[i].ipc]));
      end
    end

    // stall at word 3, then jump from DRAIN, then async reset mid-stall
    do_reset();
    cyc(1,0,0,0,1);
    chk("st_first", 32'(instr_valid), 0);
    for (int p = 0; p < 4; p++) cyc(1,0,0,0,1);
    chk_word("st_w3", 3);
    for (int k = 0; k < 3; k++) begin
      cyc(1,0,0,0,0);
      chk_word("st_hold", 3);
      chk("st_addr", 32'(imem_addr), 4);
    end
    cyc(1,0,0,0,1);
    chk_word("st_resume", 4);
    for (int p = 5; p < 15; p++) cyc(1,0,0,0,1);
    chk_word("dr_w14", 14);
    chk("dr_addr", 32'(imem_addr), 14);
    cyc(1,0,1,0,0);
    chk("dr_drop", 32'(instr_valid), 0);
    chk("dr_halted", 32'(halted), 0);
    cyc(1,0,0,0,0);
    chk_word("dr_refetch", 0);
    cyc(1,0,0,0,0);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(instr_valid), 0);
    chk("ar_addr", 32'(imem_addr), 0);
    chk("ar_pc", 32'(instr_pc), 0);
    chk("ar_instr", 32'(instr), 0);
    chk("ar_halted", 32'(halted), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc(0,0,0,0,1);
      chk("ar_idle", 32'(instr_valid), 0);
    end
    cyc(1,0,0,0,1);
    chk("ar_run0", 32'(instr_valid), 0);
    cyc(1,0,0,0,1);
    chk_word("ar_run1", 0);

    // random ready/jump traffic checked against the expected word stream
    do_reset();
    for (int rnd = 0; rnd < 6; rnd++) begin
      exp_pc = 0; exp_halt = 0; seen = 0; jumped = 0; fin = 0;
      for (int c = 0; c < 400 && !fin; c++) begin
        chk("rn_halted", 32'(halted), 32'(exp_halt));
        if (jumped) chk("rn_jdrop", 32'(instr_valid), 0);
        if (instr_valid) begin
          seen = 1;
          chk("rn_pc", 32'(instr_pc), 32'(exp_pc));
          chk("rn_instr", 32'(instr), 32'(mem[exp_pc]));
        end
        if (exp_halt) begin
          fin = 1;
        end else begin
          rd = ($urandom % 4) != 0;
          je = seen && (($urandom % 16) == 0);
          ja = 8'($urandom % 15);
          jumped = je;
          if (je) exp_pc = ja;
          else if (instr_valid && rd) begin
            if (exp_pc == 14) exp_halt = 1;
            else exp_pc = exp_pc + 1;
          end
          cyc(1,0,je,ja,rd);
        end
      end
      chk("rn_done", 32'(fin), 1);
      cyc(1,1,0,0,1);
      chk("rn_restart_h", 32'(halted), 0);
      chk("rn_restart_a", 32'(imem_addr), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
